// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus for the bit-serial subtractor.
// The master side (controlling block) issues a start with the operands.
// The slave side (the subtractor) returns busy, done and the result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start,
    output a,
    output b,
    output bin,
    input  busy,
    input  done,
    input  diff,
    input  bout
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    input  bin,
    output busy,
    output done,
    output diff,
    output bout
  );

endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor computing diff = a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell is reused every cycle. The borrow is carried in a flop
// between bits. The result is assembled in a private shift register and copied to
// diff/bout only on the last bit, so partial results never appear on the outputs.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  sub
);

  // The counter must hold values 0..WIDTH.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] b_d;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] diff_d;
  logic             br_q;
  logic             br_d;
  logic             bout_q;
  logic             bout_d;
  logic             done_q;
  logic             done_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;

  logic             a0;
  logic             b0;
  logic             d_bit;
  logic             borrow_next;
  logic             last_bit;

  // One full-subtractor cell acting on the low bits of the operand shift registers.
  always_comb begin
    a0          = a_q[0];
    b0          = b_q[0];
    d_bit       = a0 ^ b0 ^ br_q;
    borrow_next = (~a0 & b0) | (~(a0 ^ b0) & br_q);
    last_bit    = (cnt_q == CW'(WIDTH - 1));
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Start is only looked at while idle, so a start during a run is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (sub.start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the state and the result/flag registers.
  always_comb begin
    sub.busy = (state_q == RUN);
    sub.done = done_q;
    sub.diff = diff_q;
    sub.bout = bout_q;
  end

  // Datapath next values: load on an accepted start, shift one bit per RUN cycle.
  // The result is published on the last bit.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    br_d   = br_q;
    cnt_d  = cnt_q;
    diff_d = diff_q;
    bout_d = bout_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sub.start) begin
          a_d   = sub.a;
          b_d   = sub.b;
          br_d  = sub.bin;
          res_d = '0;
          cnt_d = '0;
        end
      end
      RUN: begin
        res_d            = res_q >> 1;
        res_d[WIDTH-1]   = d_bit;
        a_d              = a_q >> 1;
        b_d              = b_q >> 1;
        br_d             = borrow_next;
        cnt_d            = cnt_q + CW'(1);
        if (last_bit) begin
          diff_d = res_d;
          bout_d = borrow_next;
          done_d = 1'b1;
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // Datapath registers, all cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      res_q  <= res_d;
      br_q   <= br_d;
      cnt_q  <= cnt_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
      done_q <= done_d;
    end
  end

endmodule
